// File: rtl/encode_motion_vector_if.sv
// rtl/encode_motion_vector_if.sv - request/result handshake bundle for the motion vector encoder
//   master: requester side (drives in_valid/in_pred/in_vec/out_ready)
//   slave : encoder side (drives in_ready/out_valid/out_bits/out_len/out_pred/out_err)
interface encode_motion_vector_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pred;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits;
    logic [4:0]  out_len;
    logic [31:0] out_pred;
    logic        out_err;

    modport master (
        output in_valid, in_pred, in_vec, out_ready,
        input  in_ready, out_valid, out_bits, out_len, out_pred, out_err
    );

    modport slave (
        input  in_valid, in_pred, in_vec, out_ready,
        output in_ready, out_valid, out_bits, out_len, out_pred, out_err
    );
endinterface

// File: rtl/encode_motion_vector.sv
// rtl/encode_motion_vector.sv - MPEG-2 motion vector component encoder (motion_code VLC + sign + residual)
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : encode_motion_vector_if.slave
//         in_valid/in_ready/in_pred/in_vec     request (predictor, target vector)
//         out_valid/out_ready                  result handshake
//         out_bits (MSB-first, left-aligned), out_len, out_pred (updated predictor), out_err
module encode_motion_vector #(
    parameter int R_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    encode_motion_vector_if.slave bus
);
    localparam int F     = 1 << R_SIZE;
    localparam int RANGE = 16 * F;

    localparam logic signed [31:0] VEC_LO = -RANGE;
    localparam logic signed [31:0] VEC_HI = RANGE - 1;
    localparam logic signed [31:0] WRAP   = 2 * RANGE;
    localparam logic [31:0]        RMASK  = F - 1;

    typedef enum logic [1:0] {IDLE, CALC, PACK, OUT} state_t;

    state_t state, state_nxt;

    logic signed [31:0] pred_q, vec_q;
    logic               err_q, zero_q, sign_q;
    logic [4:0]         code_q;
    logic [7:0]         resid_q;

    logic [31:0] bits_q, opred_q;
    logic [4:0]  len_q;
    logic        oerr_q;

    // {length[3:0], code right-aligned[10:0]}
    function automatic logic [14:0] vlc_lookup(input logic [4:0] code);
        case (code)
            5'd0:    vlc_lookup = {4'd1,  11'd1};
            5'd1:    vlc_lookup = {4'd2,  11'd1};
            5'd2:    vlc_lookup = {4'd3,  11'd1};
            5'd3:    vlc_lookup = {4'd4,  11'd1};
            5'd4:    vlc_lookup = {4'd6,  11'd3};
            5'd5:    vlc_lookup = {4'd7,  11'd5};
            5'd6:    vlc_lookup = {4'd7,  11'd4};
            5'd7:    vlc_lookup = {4'd7,  11'd3};
            5'd8:    vlc_lookup = {4'd9,  11'd11};
            5'd9:    vlc_lookup = {4'd9,  11'd10};
            5'd10:   vlc_lookup = {4'd9,  11'd9};
            5'd11:   vlc_lookup = {4'd10, 11'd17};
            5'd12:   vlc_lookup = {4'd10, 11'd16};
            5'd13:   vlc_lookup = {4'd10, 11'd15};
            5'd14:   vlc_lookup = {4'd10, 11'd14};
            5'd15:   vlc_lookup = {4'd10, 11'd13};
            5'd16:   vlc_lookup = {4'd10, 11'd12};
            default: vlc_lookup = {4'd0,  11'd0};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = CALC;
            CALC:    state_nxt = PACK;
            PACK:    state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Delta with a single modular wrap into [-16f, 16f-1], then split into code and residual.
    logic signed [31:0] delta_raw, delta;
    logic [31:0]        abs_delta, abs_m1, code_full;
    logic               vec_err;

    always_comb begin
        delta_raw = vec_q - pred_q;
        delta     = delta_raw;
        if (delta_raw < VEC_LO)      delta = delta_raw + WRAP;
        else if (delta_raw > VEC_HI) delta = delta_raw - WRAP;
        abs_delta = delta[31] ? 32'(-delta) : 32'(delta);
        abs_m1    = abs_delta - 32'd1;
        code_full = (abs_m1 >> R_SIZE) + 32'd1;
        vec_err   = (vec_q < VEC_LO) || (vec_q > VEC_HI);
    end

    // Assemble VLC, sign and residual right-aligned, then left-align into 32 bits.
    logic [14:0] vlc;
    logic [31:0] word, packed_bits;
    logic [4:0]  plen;

    always_comb begin
        vlc  = vlc_lookup(code_q);
        word = {21'd0, vlc[10:0]};
        plen = {1'b0, vlc[14:11]};
        if (!zero_q) begin
            word = {word[30:0], sign_q};
            plen = plen + 5'd1;
            if (R_SIZE > 0) begin
                word = (word << R_SIZE) | {24'd0, resid_q};
                plen = plen + 5'(R_SIZE);
            end
        end
        packed_bits = word << (6'd32 - {1'b0, plen});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_q  <= '0;
            vec_q   <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            code_q  <= '0;
            resid_q <= '0;
            bits_q  <= '0;
            len_q   <= '0;
            opred_q <= '0;
            oerr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pred_q <= bus.in_pred;
                        vec_q  <= bus.in_vec;
                    end
                end
                CALC: begin
                    err_q   <= vec_err;
                    zero_q  <= (delta == 32'sd0);
                    sign_q  <= delta[31];
                    code_q  <= (delta == 32'sd0) ? 5'd0 : code_full[4:0];
                    resid_q <= 8'(abs_m1 & RMASK);
                end
                PACK: begin
                    oerr_q <= err_q;
                    if (err_q) begin
                        bits_q  <= '0;
                        len_q   <= '0;
                        opred_q <= pred_q;
                    end else begin
                        bits_q  <= packed_bits;
                        len_q   <= plen;
                        opred_q <= vec_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.out_bits  = bits_q;
    assign bus.out_len   = len_q;
    assign bus.out_pred  = opred_q;
    assign bus.out_err   = oerr_q;
endmodule

// File: tb/tb_encode_motion_vector.sv
// tb/tb_encode_motion_vector.sv - directed self-checking bench for encode_motion_vector
module tb_encode_motion_vector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    encode_motion_vector_if if0 ();
    encode_motion_vector_if if2 ();

    encode_motion_vector #(.R_SIZE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    encode_motion_vector #(.R_SIZE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int n_checks = 0;
    int n_fail   = 0;
    bit sel      = 1'b0;

    wire        obs_ready = sel ? if2.in_ready  : if0.in_ready;
    wire        obs_valid = sel ? if2.out_valid : if0.out_valid;
    wire [31:0] obs_bits  = sel ? if2.out_bits  : if0.out_bits;
    wire [4:0]  obs_len   = sel ? if2.out_len   : if0.out_len;
    wire [31:0] obs_pred  = sel ? if2.out_pred  : if0.out_pred;
    wire        obs_err   = sel ? if2.out_err   : if0.out_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] p, input logic [31:0] q);
        if (sel) begin
            if2.in_valid = v; if2.in_pred = p; if2.in_vec = q;
        end else begin
            if0.in_valid = v; if0.in_pred = p; if0.in_vec = q;
        end
    endtask

    task automatic set_ready(input logic r);
        if0.out_ready = r;
        if2.out_ready = r;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!obs_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":latency"}, n, 2);
    endtask

    task automatic encode(input string tag, input int p, input int v, input logic [31:0] eb,
                          input int el, input int ep, input logic ee);
        @(negedge clk); set_in(1'b1, p, v);
        @(posedge clk); #1; set_in(1'b0, 0, 0);
        check({tag, ":busy"}, {31'd0, obs_ready}, 0);
        wait_valid(tag);
        check({tag, ":bits"}, obs_bits, eb);
        check({tag, ":len"},  {27'd0, obs_len}, el);
        check({tag, ":pred"}, obs_pred, ep);
        check({tag, ":err"},  {31'd0, obs_err}, {31'd0, ee});
        @(posedge clk); #1;
        check({tag, ":idle"}, {30'd0, obs_ready, obs_valid}, 32'd2);
    endtask

    initial begin
        bit seen;
        set_ready(1'b1);
        sel = 1'b1; set_in(1'b0, 0, 0);
        sel = 1'b0; set_in(1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst:ready", {31'd0, obs_ready}, 1);
        check("rst:valid", {31'd0, obs_valid}, 0);
        check("rst:bits",  obs_bits, 0);
        check("rst:len",   {27'd0, obs_len}, 0);
        check("rst:pred",  obs_pred, 0);
        check("rst:err",   {31'd0, obs_err}, 0);
        @(negedge clk); rst = 1'b1;

        // R_SIZE = 0
        encode("r0_zero",  0,  0, 32'h8000_0000,  1,  0, 1'b0);
        encode("r0_pos2",  1,  3, 32'h2000_0000,  4,  3, 1'b0);
        encode("r0_neg1",  0, -1, 32'h6000_0000,  3, -1, 1'b0);
        encode("r0_wrap", -1, 15, 32'h0320_0000, 11, 15, 1'b0);
        encode("r0_err",   5, 16, 32'h0000_0000,  0,  5, 1'b1);
        encode("r0_lo",    0,-16, 32'h0320_0000, 11,-16, 1'b0);

        // R_SIZE = 2
        sel = 1'b1;
        encode("r2_wrap", 60, -60, 32'h2C00_0000,  6, -60, 1'b0);
        encode("r2_res0",  0,   5, 32'h2000_0000,  6,   5, 1'b0);
        encode("r2_max",   0, -64, 32'h0338_0000, 13, -64, 1'b0);
        encode("r2_err",   7,  64, 32'h0000_0000,  0,   7, 1'b1);
        sel = 1'b0;

        // Backpressure: outputs hold and extra requests are ignored
        set_ready(1'b0);
        @(negedge clk); set_in(1'b1, 1, 3);
        @(posedge clk); #1; set_in(1'b0, 0, 0);
        wait_valid("hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); set_in(1'b1, 7, 9);
            @(posedge clk); #1;
            check("hold:valid", {31'd0, obs_valid}, 1);
            check("hold:ready", {31'd0, obs_ready}, 0);
            check("hold:bits",  obs_bits, 32'h2000_0000);
            check("hold:len",   {27'd0, obs_len}, 4);
            check("hold:pred",  obs_pred, 3);
        end
        @(negedge clk); set_in(1'b0, 0, 0); set_ready(1'b1);
        @(posedge clk); #1;
        check("hold:release", {30'd0, obs_ready, obs_valid}, 32'd2);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (obs_valid) seen = 1'b1;
        end
        check("hold:no_queue", {31'd0, seen}, 0);

        // Reset while in PACK discards the request
        @(negedge clk); set_in(1'b1, 0, 5);
        @(posedge clk); #1; set_in(1'b0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst:ready", {31'd0, obs_ready}, 1);
        check("mid_rst:valid", {31'd0, obs_valid}, 0);
        check("mid_rst:bits",  obs_bits, 0);
        check("mid_rst:len",   {27'd0, obs_len}, 0);
        check("mid_rst:pred",  obs_pred, 0);
        @(negedge clk); rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (obs_valid) seen = 1'b1;
        end
        check("mid_rst:dropped", {31'd0, seen}, 0);
        encode("post_rst", 1, 3, 32'h2000_0000, 4, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
